ser_trama: RTL and testbench



---
 rtl/ser_trama.sv | 144 ++++++++++++++
 tb/tb_ser_trama.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ser_trama.sv
// ser_trama: frame serializer (start pattern, MSB-first payload, zero trailer); optional parity bit with SER_TRAMA_PARIDAD_EN
module ser_trama #(
  parameter int                   LARGO_SEC  = 5,
  parameter logic [LARGO_SEC-1:0] SECUENCIA  = 5'b10100,
  parameter int                   ANCHO_DATO = 8,
  parameter int                   N_CEROS    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ANCHO_DATO-1:0] dato_in,
  input  logic                  dato_valido,
  output logic                  listo,
  output logic                  s_out,
  output logic                  ocupado,
  output logic                  fin_trama
);
  localparam int MAX_AB = (LARGO_SEC > ANCHO_DATO) ? LARGO_SEC : ANCHO_DATO;
  localparam int MAXV   = (MAX_AB > N_CEROS) ? MAX_AB : N_CEROS;
  localparam int CW     = $clog2(MAXV + 1);

  typedef enum logic [2:0] {
    INICIO    = 3'd0,
    PREAMBULO = 3'd1,
    DATOS     = 3'd2,
`ifdef SER_TRAMA_PARIDAD_EN
    PARIDAD   = 3'd3,
`endif
    COLA      = 3'd4
  } estado_t;

  estado_t               r_est;
  logic [CW-1:0]         r_cnt;
  logic [ANCHO_DATO-1:0] r_sh;
  logic                  r_s;
  logic                  r_listo;
  logic                  r_ocup;
  logic                  r_fin;
  logic [LARGO_SEC-1:0]  w_sec;
`ifdef SER_TRAMA_PARIDAD_EN
  logic                  r_par;
`endif

  // start-pattern bit that follows the one currently on the line sits at the MSB
  assign w_sec = SECUENCIA << (r_cnt + 1'b1);

  assign listo     = r_listo;
  assign s_out     = r_s;
  assign ocupado   = r_ocup;
  assign fin_trama = r_fin;

  // frame sequencer: all outputs registered, counter reloaded on every state change
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_est   <= INICIO;
      r_cnt   <= '0;
      r_sh    <= '0;
      r_s     <= 1'b0;
      r_listo <= 1'b0;
      r_ocup  <= 1'b0;
      r_fin   <= 1'b0;
`ifdef SER_TRAMA_PARIDAD_EN
      r_par   <= 1'b0;
`endif
    end else begin
      case (r_est)
        INICIO: begin
          r_fin <= 1'b0;
          if (dato_valido && r_listo) begin
            r_est   <= PREAMBULO;
            r_cnt   <= '0;
            r_s     <= SECUENCIA[LARGO_SEC-1];
            r_sh    <= dato_in;
            r_listo <= 1'b0;
            r_ocup  <= 1'b1;
`ifdef SER_TRAMA_PARIDAD_EN
            r_par   <= ^dato_in;
`endif
          end else begin
            r_s     <= 1'b0;
            r_listo <= 1'b1;
            r_ocup  <= 1'b0;
          end
        end
        PREAMBULO: begin
          if (r_cnt == CW'(LARGO_SEC - 1)) begin
            r_est <= DATOS;
            r_cnt <= '0;
            r_s   <= r_sh[ANCHO_DATO-1];
            r_sh  <= r_sh << 1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            r_s   <= w_sec[LARGO_SEC-1];
          end
        end
        DATOS: begin
          if (r_cnt == CW'(ANCHO_DATO - 1)) begin
            r_cnt <= '0;
`ifdef SER_TRAMA_PARIDAD_EN
            r_est <= PARIDAD;
            r_s   <= r_par;
`else
            r_est <= COLA;
            r_s   <= 1'b0;
            r_fin <= (N_CEROS == 1);
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
            r_s   <= r_sh[ANCHO_DATO-1];
            r_sh  <= r_sh << 1;
          end
        end
`ifdef SER_TRAMA_PARIDAD_EN
        PARIDAD: begin
          r_est <= COLA;
          r_cnt <= '0;
          r_s   <= 1'b0;
          r_fin <= (N_CEROS == 1);
        end
`endif
        COLA: begin
          r_s <= 1'b0;
          if (r_cnt == CW'(N_CEROS - 1)) begin
            r_est   <= INICIO;
            r_cnt   <= '0;
            r_fin   <= 1'b0;
            r_listo <= 1'b1;
            r_ocup  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            r_fin <= (r_cnt + 1'b1 == CW'(N_CEROS - 1));
          end
        end
        default: begin
          r_est   <= INICIO;
          r_cnt   <= '0;
          r_s     <= 1'b0;
          r_listo <= 1'b0;
          r_ocup  <= 1'b0;
          r_fin   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ser_trama.sv
// tb_ser_trama: directed self-checking bench for ser_trama (honours SER_TRAMA_PARIDAD_EN)
module tb_ser_trama;
`ifdef SER_TRAMA_PARIDAD_EN
  localparam int F = 19;
`else
  localparam int F = 18;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dato_in;
  logic       dato_valido;
  logic       listo, s_out, ocupado, fin_trama;
  int         n_tests = 0;
  int         n_fail  = 0;

  ser_trama dut (
    .clk(clk), .rst(rst), .dato_in(dato_in), .dato_valido(dato_valido),
    .listo(listo), .s_out(s_out), .ocupado(ocupado), .fin_trama(fin_trama)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [F-1:0] exp_frame(input logic [7:0] d);
`ifdef SER_TRAMA_PARIDAD_EN
    return {5'b10100, d, ^d, 5'b00000};
`else
    return {5'b10100, d, 5'b00000};
`endif
  endfunction

  // called one #1 after the accept edge; returns in the idle cycle after the frame
  task automatic frame(input string nm, input logic [F-1:0] e, input int inj);
    for (int i = 1; i <= F; i++) begin
      if (inj > 0 && i == inj) begin
        dato_in = 8'h12;
        dato_valido = 1'b1;
      end else if (inj > 0 && i == inj + 1) begin
        dato_valido = 1'b0;
      end
      chk($sformatf("%s s_out c%0d", nm, i), s_out, e[F-i]);
      chk($sformatf("%s fin c%0d", nm, i), fin_trama, i == F);
      chk($sformatf("%s ocupado c%0d", nm, i), ocupado, 1'b1);
      chk($sformatf("%s listo c%0d", nm, i), listo, 1'b0);
      tick();
    end
    chk({nm, " listo after"}, listo, 1'b1);
    chk({nm, " s_out after"}, s_out, 1'b0);
    chk({nm, " ocupado after"}, ocupado, 1'b0);
    chk({nm, " fin after"}, fin_trama, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    dato_in = 8'h00;
    dato_valido = 1'b0;
    tick();
    tick();
    chk("rst listo", listo, 1'b0);
    chk("rst s_out", s_out, 1'b0);
    chk("rst ocupado", ocupado, 1'b0);
    chk("rst fin", fin_trama, 1'b0);
    rst = 1'b0;
    chk("listo before edge", listo, 1'b0);
    tick();
    chk("listo after release", listo, 1'b1);
    chk("idle s_out", s_out, 1'b0);

    dato_in = 8'hA5;
    dato_valido = 1'b1;
    tick();
    dato_valido = 1'b0;
`ifdef SER_TRAMA_PARIDAD_EN
    frame("A5", 19'b10100_10100101_0_00000, 0);
`else
    frame("A5", 18'b10100_10100101_00000, 0);
`endif

    dato_in = 8'h3C;
    dato_valido = 1'b1;
    tick();
    dato_in = 8'hFF;
    frame("3C", exp_frame(8'h3C), 0);
    tick();
    dato_valido = 1'b0;
    frame("FF", exp_frame(8'hFF), 0);
    tick();
    chk("no second FF ocupado", ocupado, 1'b0);
    chk("no second FF s_out", s_out, 1'b0);

    dato_in = 8'h80;
    dato_valido = 1'b1;
    tick();
    dato_valido = 1'b0;
    frame("80", exp_frame(8'h80), 8);
    tick();
    chk("12 ignored ocupado", ocupado, 1'b0);
    chk("12 ignored listo", listo, 1'b1);

    dato_in = 8'hC3;
    dato_valido = 1'b1;
    tick();
    dato_valido = 1'b0;
    repeat (8) tick();
    chk("pre-abort ocupado", ocupado, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("abort s_out", s_out, 1'b0);
    chk("abort listo", listo, 1'b0);
    chk("abort ocupado", ocupado, 1'b0);
    chk("abort fin", fin_trama, 1'b0);
    tick();
    rst = 1'b0;
    chk("abort listo held", listo, 1'b0);
    tick();
    chk("abort listo release", listo, 1'b1);
    chk("abort s_out idle", s_out, 1'b0);
    chk("abort ocupado idle", ocupado, 1'b0);
    dato_in = 8'h55;
    dato_valido = 1'b1;
    tick();
    dato_valido = 1'b0;
    frame("55", exp_frame(8'h55), 0);

`ifdef SER_TRAMA_PARIDAD_EN
    dato_in = 8'h07;
    dato_valido = 1'b1;
    tick();
    dato_valido = 1'b0;
    frame("07", 19'b10100_00000111_1_00000, 0);
    dato_in = 8'h03;
    dato_valido = 1'b1;
    tick();
    dato_valido = 1'b0;
    frame("03", 19'b10100_00000011_0_00000, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
